// File: rtl/isp_stage_sequencer_if.sv
// rtl/isp_stage_sequencer_if.sv - stage-side bundle between the sequencer and the ISP pixel stages
//
// Purpose: carries the per-stage launch/done handshake plus the latched frame
// geometry and the index of the stage currently launched or awaited.
// Signals:
//   stage_start  one-hot 1-cycle launch pulse per stage (stage new_trans)
//   stage_done   per-stage completion pulses
//   max_x/max_y  latched frame geometry, stable while the sequencer is busy
//   cur_stage    index of the stage launched/awaited
// Modports: master = sequencer, slave = stage side.
interface isp_stage_sequencer_if #(
  parameter int XW         = 8,
  parameter int YW         = 8,
  parameter int NUM_STAGES = 3,
  parameter int SW         = 2
);
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  logic [XW-1:0]         max_x;
  logic [YW-1:0]         max_y;
  logic [SW-1:0]         cur_stage;

  modport master (
    output stage_start, max_x, max_y, cur_stage,
    input  stage_done
  );

  modport slave (
    input  stage_start, max_x, max_y, cur_stage,
    output stage_done
  );
endinterface

// File: rtl/isp_stage_sequencer.sv
// rtl/isp_stage_sequencer.sv - frame-level launch/wait sequencer for the ISP pixel stages
//
// Purpose: on a frame start, latches stage mask and geometry, then launches each
// enabled stage (lowest index first) with a 1-cycle pulse and waits for its done.
// Optional watchdog on the WAIT state: define ISP_SEQ_WATCHDOG_EN.
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   start, abort          frame start pulse, cancel current frame
//   stage_mask            stage enable bits, sampled with start
//   cfg_max_x/cfg_max_y   frame width-1 / height-1, sampled with start
//   stg                   stage-side bundle (master modport)
//   busy                  high in any state but IDLE
//   frame_done            1-cycle frame-complete pulse
//   err                   sticky error (stray done / watchdog timeout)
//   frame_cnt             completed-frame counter, wraps
module isp_stage_sequencer #(
  parameter int X_MAX      = 200,
  parameter int Y_MAX      = 200,
  parameter int NUM_STAGES = 3,
  parameter int WDT_CYCLES = 65536,
  localparam int XW        = $clog2(X_MAX),
  localparam int YW        = $clog2(Y_MAX),
  localparam int SW        = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [XW-1:0]         cfg_max_x,
  input  logic [YW-1:0]         cfg_max_y,
  isp_stage_sequencer_if.master stg,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE} state_t;

  localparam logic [NUM_STAGES-1:0] ONE = NUM_STAGES'(1);

  state_t                state_q;
  logic [NUM_STAGES-1:0] mask_q;
  logic [SW-1:0]         idx_q;
  logic [XW-1:0]         max_x_q;
  logic [YW-1:0]         max_y_q;
  logic [NUM_STAGES-1:0] stage_start_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  err_q;
  logic [15:0]           frame_cnt_q;

  // Lowest enabled stage of the incoming mask, and next enabled stage above idx_q.
  logic          first_found;
  logic [SW-1:0] first_idx;
  logic          next_found;
  logic [SW-1:0] next_idx;
  logic          awaited_done;
  logic          stray_done;

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_mask[i]) begin
        first_found = 1'b1;
        first_idx   = SW'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_found = 1'b1;
        next_idx   = SW'(i);
      end
    end
    awaited_done = |(stg.stage_done & (ONE << idx_q));
    stray_done   = |(stg.stage_done & ~(ONE << idx_q));
  end

`ifdef ISP_SEQ_WATCHDOG_EN
  logic [16:0] wdt_cnt;
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      max_x_q       <= '0;
      max_y_q       <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
`ifdef ISP_SEQ_WATCHDOG_EN
      wdt_cnt       <= '0;
`endif
    end else begin
      stage_start_q <= '0;
      frame_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            mask_q  <= stage_mask;
            max_x_q <= cfg_max_x;
            max_y_q <= cfg_max_y;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            if (first_found) begin
              idx_q         <= first_idx;
              stage_start_q <= ONE << first_idx;
              state_q       <= S_LAUNCH;
            end else begin
              // Empty frame walks through NEXT so it finishes like a last stage.
              state_q <= S_NEXT;
            end
          end
        end
        S_LAUNCH: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_WAIT;
`ifdef ISP_SEQ_WATCHDOG_EN
            wdt_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (stray_done) err_q <= 1'b1;
            if (awaited_done) begin
              state_q <= S_NEXT;
            end
`ifdef ISP_SEQ_WATCHDOG_EN
            // Fires on the edge where the count would reach WDT_CYCLES-1.
            else if (wdt_cnt == 17'(WDT_CYCLES - 2)) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              wdt_cnt <= wdt_cnt + 17'd1;
            end
`endif
          end
        end
        S_NEXT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (next_found) begin
            idx_q         <= next_idx;
            stage_start_q <= ONE << next_idx;
            state_q       <= S_LAUNCH;
          end else begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            state_q      <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stg.stage_start = stage_start_q;
  assign stg.max_x       = max_x_q;
  assign stg.max_y       = max_y_q;
  assign stg.cur_stage   = idx_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign err             = err_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_isp_stage_sequencer.sv
// tb/tb_isp_stage_sequencer.sv - directed self-checking bench for isp_stage_sequencer
module tb_isp_stage_sequencer;
  localparam int NS = 3;
  localparam int XW = 8;
  localparam int YW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_mask = '0;
  logic [NS-1:0] man_done = '0;
  logic [NS-1:0] resp_done;
  logic [XW-1:0] cfg_max_x = '0;
  logic [YW-1:0] cfg_max_y = '0;
  logic          busy;
  logic          frame_done;
  logic          err;
  logic [15:0]   frame_cnt;

  isp_stage_sequencer_if #(.XW(XW), .YW(YW), .NUM_STAGES(NS), .SW(SW)) sif ();

  isp_stage_sequencer #(
    .X_MAX(200), .Y_MAX(200), .NUM_STAGES(NS), .WDT_CYCLES(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .stage_mask(stage_mask), .cfg_max_x(cfg_max_x), .cfg_max_y(cfg_max_y),
    .stg(sif.master), .busy(busy), .frame_done(frame_done), .err(err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: each launched stage pulses done dly cycles after its start.
  bit resp_en = 1'b1;
  int dly = 5;
  int due [NS] = '{default: -1};

  always_comb begin
    resp_done = '0;
    for (int i = 0; i < NS; i++) resp_done[i] = resp_en && (due[i] == cyc);
  end
  assign sif.stage_done = resp_done | man_done;

  int ss_cyc[$];
  int ss_idx[$];
  int fd_cyc[$];
  int hold_bad = 0;
  logic [XW-1:0] exp_x = '0;
  logic [YW-1:0] exp_y = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (sif.stage_start[i]) begin
        ss_cyc.push_back(cyc);
        ss_idx.push_back(i);
        due[i] = cyc + dly;
      end
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (busy && (sif.max_x != exp_x || sif.max_y != exp_y)) hold_bad++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic clear_logs();
    ss_cyc.delete();
    ss_idx.delete();
    fd_cyc.delete();
  endtask

  // Drives a start for one cycle; returns the cycle in which start was high.
  task automatic frame_start(input logic [NS-1:0] m, input int x, input int y, output int k);
    clear_logs();
    stage_mask = m;
    cfg_max_x  = XW'(x);
    cfg_max_y  = YW'(y);
    exp_x      = XW'(x);
    exp_y      = YW'(y);
    start      = 1'b1;
    k          = cyc;
    step(1);
    start      = 1'b0;
  endtask

  initial begin
    int k;
    int k2;

    step(2);
    check("rst_ctl", {busy, frame_done, err, sif.stage_start, sif.cur_stage}, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_geom", {sif.max_x, sif.max_y}, 0);
    #2 n_rst = 1'b1;
    step(2);

    // Full frame, plus a start and config/mask changes while busy.
    frame_start(3'b111, 9, 7, k);
    stage_mask = '0;
    cfg_max_x  = 8'd0;
    goto(k + 10);
    start = 1'b1;
    stage_mask = 3'b010;
    step(1);
    start = 1'b0;
    goto(k + 30);
    check("full_nstarts", ss_cyc.size(), 3);
    check("full_s0_cyc", ss_cyc[0], k + 1);
    check("full_s0_idx", ss_idx[0], 0);
    check("full_s1_cyc", ss_cyc[1], k + 8);
    check("full_s1_idx", ss_idx[1], 1);
    check("full_s2_cyc", ss_cyc[2], k + 15);
    check("full_s2_idx", ss_idx[2], 2);
    check("full_nfd", fd_cyc.size(), 1);
    check("full_fd_cyc", fd_cyc[0], k + 22);
    check("full_cnt", frame_cnt, 1);
    check("full_err", err, 0);
    check("full_busy", busy, 0);

    // Skip stage 1.
    frame_start(3'b101, 20, 30, k);
    goto(k + 20);
    check("skip_nstarts", ss_cyc.size(), 2);
    check("skip_s2_cyc", ss_cyc[1], k + 8);
    check("skip_s2_idx", ss_idx[1], 2);
    check("skip_fd_cyc", fd_cyc[0], k + 15);
    check("skip_cnt", frame_cnt, 2);

    // Empty frame.
    frame_start(3'b000, 3, 4, k);
    goto(k + 6);
    check("empty_nstarts", ss_cyc.size(), 0);
    check("empty_nfd", fd_cyc.size(), 1);
    check("empty_fd_cyc", fd_cyc[0], k + 2);
    check("empty_cnt", frame_cnt, 3);

    // Abort together with start in IDLE: start ignored.
    clear_logs();
    stage_mask = 3'b111;
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    step(4);
    check("idle_abort_nstarts", ss_cyc.size(), 0);
    check("idle_abort_cnt", frame_cnt, 3);

    // Abort while waiting on stage 1, with a config change mid-frame.
    frame_start(3'b111, 9, 7, k);
    goto(k + 4);
    cfg_max_x = 8'd50;
    cfg_max_y = 8'd60;
    goto(k + 10);
    check("abort_cur_stage", sif.cur_stage, 1);
    check("abort_busy_pre", busy, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy_post", busy, 0);
    goto(k + 25);
    check("abort_nfd", fd_cyc.size(), 0);
    check("abort_cnt", frame_cnt, 3);
    check("abort_max_x", sif.max_x, 9);
    check("abort_cur_hold", sif.cur_stage, 1);
    check("abort_err", err, 0);

    // Stray done on stage 2 while waiting on stage 0.
    frame_start(3'b111, 9, 7, k);
    goto(k + 3);
    man_done = 3'b100;
    step(1);
    man_done = '0;
    check("stray_err", err, 1);
    goto(k + 30);
    check("stray_fd_cyc", fd_cyc[0], k + 22);
    check("stray_cnt", frame_cnt, 4);
    check("stray_err_sticky", err, 1);
    frame_start(3'b000, 9, 7, k2);
    check("stray_err_clear", err, 0);
    goto(k2 + 5);
    check("stray_cnt2", frame_cnt, 5);

    // Stage 0 never completes.
    resp_en = 1'b0;
    frame_start(3'b001, 9, 7, k);
`ifdef ISP_SEQ_WATCHDOG_EN
    goto(k + 16);
    check("wdt_busy_pre", busy, 1);
    step(1);
    check("wdt_busy_post", busy, 0);
    check("wdt_err", err, 1);
    check("wdt_nfd", fd_cyc.size(), 0);
    check("wdt_cnt", frame_cnt, 5);
`else
    goto(k + 40);
    check("hang_busy", busy, 1);
    check("hang_cur", sif.cur_stage, 0);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("hang_abort_busy", busy, 0);
    check("hang_nfd", fd_cyc.size(), 0);
`endif
    resp_en = 1'b1;

    // Reset mid-frame.
    frame_start(3'b111, 11, 12, k);
    goto(k + 3);
    n_rst = 1'b0;
    #1;
    check("midrst_ctl", {busy, frame_done, err, sif.stage_start, sif.cur_stage}, 0);
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_geom", {sif.max_x, sif.max_y}, 0);
    step(2);
    #2 n_rst = 1'b1;
    step(2);
    frame_start(3'b000, 1, 1, k);
    goto(k + 5);
    check("after_rst_cnt", frame_cnt, 1);

    check("geom_hold", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
